// File: rtl/busca_instrucao.sv
// Instruction fetch unit for the single-cycle MIPS datapath: owns the PC, fetches over req/ready,
// presents one instruction per EXEC cycle. Optional perf counters behind `PERF_CNT_EN`.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | not fetching; waits for run
// ST_FETCH | imem_req high at imem_addr = pc until imem_ready
// ST_EXEC  | instrucao valid for one cycle; next pc selected at its edge
// ST_ERROR | memory timeout; pc frozen, only reset leaves
module busca_instrucao #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrucao,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        jump,
  input  logic        branch,
  input  logic        ALUZero,
  input  logic [31:0] fetchInstrucao,
  output logic        fetch_error
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] retired_count,
  output logic [31:0] redirect_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] TIMEOUT_LIMIT    = TIMEOUT_CYCLES;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] wait_q, wait_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        take_branch;
  logic        redirect;

  // The immediate arrives sign-extended; its top two bits fall off the word shift.
  logic unused_imm_bits;
  assign unused_imm_bits = ^fetchInstrucao[31:30];

  assign pc_plus4      = pc_q + 32'd4;
  assign jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign branch_target = pc_plus4 + {fetchInstrucao[29:0], 2'b00};
  assign take_branch   = branch & ALUZero;
  assign redirect      = jump | take_branch;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          wait_d  = 32'd0;
          state_d = ST_EXEC;
        end else begin
          wait_d = wait_q + 32'd1;
          if ((TIMEOUT_LIMIT != 32'd0) && (wait_d == TIMEOUT_LIMIT)) begin
            state_d = ST_ERROR;
          end
        end
      end

      ST_EXEC: begin
        // jump has priority over a taken branch
        if (jump) begin
          pc_d = jump_target;
        end else if (take_branch) begin
          pc_d = branch_target;
        end else begin
          pc_d = pc_plus4;
        end
        state_d = run ? ST_FETCH : ST_IDLE;
      end

      ST_ERROR: begin
        state_d = ST_ERROR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'd0;
      wait_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign instr_valid = (state_q == ST_EXEC);
  assign fetch_error = (state_q == ST_ERROR);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instrucao   = instr_q;

`ifdef PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    retired_d      = retired_q;
    redirect_cnt_d = redirect_cnt_q;
    if (state_q == ST_EXEC) begin
      retired_d = retired_q + 32'd1;
      if (redirect) begin
        redirect_cnt_d = redirect_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q      <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      retired_q      <= retired_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign retired_count  = retired_q;
  assign redirect_count = redirect_cnt_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao: stimulus pushes expected EXEC contents, a negedge monitor
// pops and compares whenever instr_valid is high, then checks the following pc.
module tb_busca_instrucao;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instrucao;
  logic        instr_valid;
  logic [31:0] pc;
  logic        jump;
  logic        branch;
  logic        ALUZero;
  logic [31:0] fetchInstrucao;
  logic        fetch_error;
`ifdef PERF_CNT_EN
  logic [31:0] retired_count;
  logic [31:0] redirect_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
  } exp_t;

  exp_t sb[$];

  busca_instrucao #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instrucao     (instrucao),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .jump          (jump),
    .branch        (branch),
    .ALUZero       (ALUZero),
    .fetchInstrucao(fetchInstrucao),
    .fetch_error   (fetch_error)
`ifdef PERF_CNT_EN
    ,
    .retired_count (retired_count),
    .redirect_count(redirect_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each EXEC against the scoreboard, then the pc one cycle later.
  logic        chk_next = 1'b0;
  logic [31:0] exp_next = 32'd0;
  always @(negedge clk) begin
    exp_t e;
    if (chk_next) begin
      check32("next_pc", pc, exp_next);
      chk_next = 1'b0;
    end
    if (instr_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_exec: got instr_valid=1 at pc=%h expected no EXEC", pc);
      end else begin
        e = sb.pop_front();
        check32("exec_pc", pc, e.pc);
        check32("exec_instr", instrucao, e.instr);
        check32("exec_addr", imem_addr, e.pc);
        check32("exec_req_low", {31'd0, imem_req}, 32'd0);
        exp_next = e.next_pc;
        chk_next = 1'b1;
      end
    end
  end

  // One fetch/execute: wait for the request, answer it, hold controls through EXEC.
  task automatic step(input logic [31:0] word, input logic j, input logic b, input logic z,
                      input logic [31:0] imm, input logic [31:0] exp_pc,
                      input logic [31:0] exp_nxt, input logic run_after, output int waited);
    waited = 0;
    @(negedge clk);
    while (!imem_req && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL fetch_req_wait: got imem_req=0 after %0d cycles expected a request", waited);
      return;
    end
    check32("fetch_addr", imem_addr, exp_pc);
    imem_rdata     = word;
    imem_ready     = 1'b1;
    jump           = j;
    branch         = b;
    ALUZero        = z;
    fetchInstrucao = imm;
    sb.push_back('{pc: exp_pc, instr: word, next_pc: exp_nxt});
    @(negedge clk);
    imem_ready = 1'b0;
    run        = run_after;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    reset          = 1'b1;
    run            = 1'b0;
    imem_ready     = 1'b0;
    imem_rdata     = 32'd0;
    jump           = 1'b0;
    branch         = 1'b0;
    ALUZero        = 1'b0;
    fetchInstrucao = 32'd0;

    repeat (2) @(negedge clk);
    check32("rst_pc", pc, 32'h0);
    check32("rst_addr", imem_addr, 32'h0);
    check32("rst_instr", instrucao, 32'h0);
    check32("rst_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst_req", {31'd0, imem_req}, 32'd0);
    check32("rst_err", {31'd0, fetch_error}, 32'd0);
    reset = 1'b0;
    run   = 1'b1;

    // Zero-wait sequential fetch: 0, 4, 8 -> pc = 0xC
    step(32'h0000_0001, 0, 0, 0, 32'h0, 32'h0000_0000, 32'h0000_0004, 1, w);
    step(32'h0000_0002, 0, 0, 0, 32'h0, 32'h0000_0004, 32'h0000_0008, 1, w);
    check32("zero_wait_2", w, 0);
    step(32'h0000_0003, 0, 0, 0, 32'h0, 32'h0000_0008, 32'h0000_000C, 1, w);
    check32("zero_wait_3", w, 0);

    // Jump to 0x100, then branch taken/not-taken with imm = -2
    step(32'h0800_0040, 1, 0, 0, 32'h0,         32'h0000_000C, 32'h0000_0100, 1, w);
    step(32'h1000_FFFE, 0, 1, 1, 32'hFFFF_FFFE, 32'h0000_0100, 32'h0000_00FC, 1, w);
    step(32'h0800_0040, 1, 0, 0, 32'h0,         32'h0000_00FC, 32'h0000_0100, 1, w);
    step(32'h1000_FFFE, 0, 1, 0, 32'hFFFF_FFFE, 32'h0000_0100, 32'h0000_0104, 1, w);

    // Large branch to 0x1000_0040, then jump+branch where jump wins
    step(32'h0000_0000, 0, 1, 1, 32'h03FF_FFCE, 32'h0000_0104, 32'h1000_0040, 1, w);
    step(32'h0800_0010, 1, 1, 1, 32'h03FF_FFCE, 32'h1000_0040, 32'h1000_0040, 1, w);

    // Branch to 0xFFFF_FFFC, then wrap to 0 with run dropped during EXEC
    step(32'h0000_0000, 0, 1, 1, 32'hFBFF_FFEE, 32'h1000_0040, 32'hFFFF_FFFC, 1, w);
    step(32'h0000_0001, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 0, w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check32("idle_req", {31'd0, imem_req}, 32'd0);
    end
    check32("idle_pc", pc, 32'h0);
    run = 1'b1;
    step(32'h0000_0005, 0, 0, 0, 32'h0, 32'h0000_0000, 32'h0000_0004, 1, w);

    // Memory never answers: four FETCH cycles then ERROR
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (imem_req) n++;
      else break;
    end
    check32("timeout_cycles", n, 4);
    check32("err_flag", {31'd0, fetch_error}, 32'd1);
    check32("err_req", {31'd0, imem_req}, 32'd0);
    check32("err_pc", pc, 32'h0000_0004);
    repeat (3) @(negedge clk);
    check32("err_sticky", {31'd0, fetch_error}, 32'd1);
    check32("err_pc_frozen", pc, 32'h0000_0004);
    check32("err_valid", {31'd0, instr_valid}, 32'd0);

    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check32("clr_err", {31'd0, fetch_error}, 32'd0);
    check32("clr_pc", pc, 32'h0);
    check32("clr_instr", instrucao, 32'h0);
    check32("clr_req", {31'd0, imem_req}, 32'd0);

    // Reset arriving together with imem_ready drops the response
    run = 1'b1;
    step(32'h0000_0009, 0, 0, 0, 32'h0, 32'h0000_0000, 32'h0000_0004, 1, w);
    @(negedge clk);
    check32("pre_rst_req", {31'd0, imem_req}, 32'd1);
    imem_rdata = 32'hDEAD_BEEF;
    imem_ready = 1'b1;
    reset      = 1'b1;
    run        = 1'b0;
    @(negedge clk);
    reset      = 1'b0;
    imem_ready = 1'b0;
    check32("rr_instr", instrucao, 32'h0);
    check32("rr_pc", pc, 32'h0);
    check32("rr_req", {31'd0, imem_req}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check32("rr_valid", {31'd0, instr_valid}, 32'd0);
    end
    check32("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction fetch unit that drives the single-cycle MIPS datapath.
- Owns the PC and fetches each word from an instruction memory using a req/ready handshake.
- Presents the fetched word on instrucao for one execute cycle.
- In that same cycle, consumes the datapath's jump/branch/ALUZero/fetchInstrucao (sign-extended immediate) outputs to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
TIMEOUT_CYCLES, 16, maximum FETCH wait cycles without imem_ready before error; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
run  input  1  enables fetching; sampled in IDLE and at the end of EXEC
imem_req  output  1  instruction memory request
imem_addr  output  32  byte address of the requested word (= pc)
imem_ready  input  1  memory response valid; imem_rdata is valid in the same cycle
imem_rdata  input  32  instruction word from memory
instrucao  output  32  registered instruction presented to the datapath
instr_valid  output  1  high exactly during the EXEC cycle
pc  output  32  current PC
jump  input  1  datapath jump control for the current instrucao
branch  input  1  datapath branch control
ALUZero  input  1  datapath ALU zero flag
fetchInstrucao  input  32  sign-extended 16-bit immediate from the datapath
fetch_error  output  1  sticky memory-timeout flag

Behaviour:
- Single clock domain: clk. reset is synchronous and active-high.
- On a clk edge with reset=1: state=IDLE, pc=RESET_PC, instrucao=0, instr_valid=0, imem_req=0, fetch_error=0, wait counter=0.
- Reset overrides every other input on that edge, including an imem_ready arriving in the same cycle (response dropped). Reset mid-FETCH drops imem_req on the next cycle.
- imem_addr = pc at all times. pc is always word-aligned.
- States: IDLE, FETCH, EXEC, ERROR. All outputs are registered or decoded from state.
- IDLE: imem_req=0, instr_valid=0. If run=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1; imem_addr is held stable until the handshake completes.
  - Handshake completes on an edge where imem_req=1 and imem_ready=1: capture imem_rdata into instrucao, clear the wait counter, go to EXEC.
  - imem_ready while imem_req=0 is ignored.
  - Each FETCH cycle without imem_ready increments the wait counter. If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, go to ERROR.
  - run is not checked in FETCH; an issued request always completes.
- EXEC (exactly 1 cycle): instr_valid=1, imem_req=0. The datapath evaluates combinationally; at the closing edge pc is updated by:
  - pc_plus4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Priority 1, jump=1: pc = {pc_plus4[31:28], instrucao[25:0], 2'b00}.
  - Priority 2, branch=1 and ALUZero=1: pc = pc_plus4 + {fetchInstrucao[29:0], 2'b00}, modulo 2^32.
  - Otherwise: pc = pc_plus4. jump and branch both high means jump wins.
  - Next state: FETCH if run=1, else IDLE.
- Throughput: 1 instruction per (2 + memory wait) cycles. With zero-wait memory (ready in the first FETCH cycle): FETCH, EXEC, FETCH, ...
- instrucao holds its value outside EXEC; instr_valid=0 outside EXEC.
- ERROR: fetch_error=1, imem_req=0, instr_valid=0, pc frozen. Exit only via reset.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs retired_count[31:0] and redirect_count[31:0].
  - Both reset to 0.
  - retired_count increments at every EXEC cycle.
  - redirect_count increments at an EXEC cycle where jump=1, or branch=1 and ALUZero=1.
  - Both wrap from 32'hFFFF_FFFF to 0 and hold in ERROR.
- Undefined: neither port nor counters exist; all other behaviour is identical.

Test Plan:
- Reset, run=1, memory ready on every request cycle, no jump/branch -> imem_addr 0,4,8 on successive FETCH cycles; instr_valid pulses every 2nd cycle; pc=0xC after 3 EXECs.
- pc=0x100, EXEC with branch=1, ALUZero=1, fetchInstrucao=0xFFFF_FFFE -> pc=0x0FC. Same with ALUZero=0 -> pc=0x104.
- pc=0x1000_0040, instrucao=0x0800_0010, jump=1, branch=1 -> pc=0x1000_0040 (jump wins).
- TIMEOUT_CYCLES=4, imem_ready held 0 -> fetch_error=1 after 4 FETCH cycles, imem_req=0, pc unchanged. reset=1 -> all outputs cleared.
- pc=0xFFFF_FFFC, no redirect -> pc=0. run dropped during EXEC -> IDLE, imem_req stays 0 until run=1.
- Reset asserted in the same cycle as imem_ready=1, imem_rdata=0xDEAD_BEEF -> instrucao=0, instr_valid never rises, pc=RESET_PC.
